// File: rtl/cmd_pkg.sv
// Shared definitions for the command dispatcher: opcode and FSM state
// encodings plus the default response bytes and move-counter width.
package cmd_pkg;

   localparam int unsigned MOVE_W_DEF = 12;
   localparam logic [7:0]  ACK_DEF    = 8'hA5;
   localparam logic [7:0]  NAK_DEF    = 8'hEE;

   // Only the opcodes that do something are named; everything else is NAK.
   typedef enum logic [3:0] {
      OP_SET_SPD = 4'h1,
      OP_MOVE    = 4'h2,
      OP_STATUS  = 4'h3
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXEC    = 3'd2,
      ST_RESP    = 3'd3,
      ST_WAIT_TX = 3'd4
   } state_e;

endpackage

// File: rtl/move_timer.sv
// Loadable down-counter that times a MOVE command.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   load_i    : load n_i into the counter at this edge
//   n_i       : move length in cycles
//   active_o  : counter is non-zero
//   last_o    : counter equals one (final cycle of the move)
module move_timer
   import cmd_pkg::*;
#(
   parameter int unsigned MOVE_W = MOVE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [MOVE_W-1:0] n_i,
   output logic              active_o,
   output logic              last_o
);

   localparam logic [MOVE_W-1:0] CNT_ZERO = {MOVE_W{1'b0}};
   localparam logic [MOVE_W-1:0] CNT_ONE  = {{(MOVE_W-1){1'b0}}, 1'b1};

   logic [MOVE_W-1:0] cnt_q;
   logic [MOVE_W-1:0] cnt_d;

   // Next count: load wins, otherwise count down and rest at zero so the
   // counter can never wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = n_i;
      end else if (cnt_q != CNT_ZERO) begin
         cnt_d = cnt_q - CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= CNT_ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign active_o = (cnt_q != CNT_ZERO);
   assign last_o   = (cnt_q == CNT_ONE);

endmodule

// File: rtl/cmd_dispatch.sv
// Command dispatcher behind the Bluetooth UART wrapper. Accepts one 16-bit
// command at a time, executes it and returns a single response byte.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   cmd_rdy_i/cmd_i : pending command from the wrapper ([15:12] op, [11:0] arg)
//   clr_cmd_rdy_o   : consumes the pending command (IDLE only)
//   resp_o/trmt_o   : response byte and its one-cycle transmit strobe
//   tx_done_i       : wrapper has finished sending the byte
//   spd_o           : speed register
//   move_en_o       : high for the N cycles of a MOVE N
//   busy_o          : a command is in flight
module cmd_dispatch
   import cmd_pkg::*;
#(
   parameter int unsigned MOVE_W = MOVE_W_DEF,
   parameter logic [7:0]  ACK    = ACK_DEF,
   parameter logic [7:0]  NAK    = NAK_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_rdy_i,
   input  logic [15:0] cmd_i,
   output logic        clr_cmd_rdy_o,
   output logic [7:0]  resp_o,
   output logic        trmt_o,
   input  logic        tx_done_i,
   output logic [7:0]  spd_o,
   output logic        move_en_o,
   output logic        busy_o
);

   state_e            state_q, state_d;
   logic [15:0]       cmd_q, cmd_d;
   logic [7:0]        spd_q, spd_d;
   logic [7:0]        resp_q, resp_d;
   logic              tmr_load_s;
   logic              tmr_active_s;
   logic              tmr_last_s;
   logic [3:0]        opcode_s;
   logic [MOVE_W-1:0] move_n_s;

   assign opcode_s = cmd_q[15:12];
   assign move_n_s = cmd_q[MOVE_W-1:0];

   move_timer #(
      .MOVE_W (MOVE_W)
   ) u_move_timer (
      .clk      (clk),
      .rst      (rst),
      .load_i   (tmr_load_s),
      .n_i      (move_n_s),
      .active_o (tmr_active_s),
      .last_o   (tmr_last_s)
   );

   // Next-state and register-update logic for the dispatcher FSM.
   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      spd_d         = spd_q;
      resp_d        = resp_q;
      tmr_load_s    = 1'b0;
      clr_cmd_rdy_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_rdy_i) begin
               cmd_d         = cmd_i;
               clr_cmd_rdy_o = 1'b1;
               state_d       = ST_DECODE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DECODE: begin
            case (opcode_s)
               OP_SET_SPD: begin
                  spd_d   = cmd_q[7:0];
                  resp_d  = ACK;
                  state_d = ST_RESP;
               end
               OP_MOVE: begin
                  if (move_n_s != {MOVE_W{1'b0}}) begin
                     tmr_load_s = 1'b1;
                     state_d    = ST_EXEC;
                  end else begin
                     resp_d  = NAK;
                     state_d = ST_RESP;
                  end
               end
               OP_STATUS: begin
                  // spd_q is the committed value, so a STATUS right after
                  // SET_SPD already sees the new speed.
                  resp_d  = spd_q;
                  state_d = ST_RESP;
               end
               default: begin
                  resp_d  = NAK;
                  state_d = ST_RESP;
               end
            endcase
         end
         ST_EXEC: begin
            if (tmr_last_s) begin
               resp_d  = ACK;
               state_d = ST_RESP;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_RESP: begin
            // tx_done may still be high from the previous byte; ignore it here.
            state_d = ST_WAIT_TX;
         end
         ST_WAIT_TX: begin
            if (tx_done_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_TX;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cmd_q   <= 16'h0000;
         spd_q   <= 8'h00;
         resp_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         spd_q   <= spd_d;
         resp_q  <= resp_d;
      end
   end

   assign spd_o     = spd_q;
   assign resp_o    = resp_q;
   assign trmt_o    = (state_q == ST_RESP);
   assign move_en_o = (state_q == ST_EXEC) && tmr_active_s;
   assign busy_o    = (state_q != ST_IDLE);

endmodule
